gray_rx_decoder: RTL and testbench

- Receiving end of a Gray-coded count link.
- Samples a Gray-coded count from a `cntr_gray`-style transmitter, which may be in another clock domain, through a synchroniser chain.
- Decodes the synchronised value to natural binary and reports the step since the previous sample.
- Flags any sample where more than one Gray bit changed; that is a coding violation or a lost count.
- Sits at the consumer side of the counter, e.g. at the read side of a pointer crossing.

---
 rtl/gray_rx_decoder.sv | 117 +++++++++++
 tb/tb_gray_rx_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/gray_rx_decoder.sv
// gray_rx_decoder: synchronises a Gray-coded count, decodes it to binary, reports step size and multi-bit violations
module gray_rx_decoder #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             en,
    input  logic             resync,
    input  logic             clr_err,
    output logic [WIDTH-1:0] binary_out,
    output logic [WIDTH-1:0] delta,
    output logic             step_valid,
    output logic             err,
    output logic [7:0]       err_cnt,
    output logic             locked
);

    localparam int HW = $clog2(WIDTH + 1);

    typedef enum logic {INIT, TRACK} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] g_sync, g_prev_q, g_prev_d;
    logic [WIDTH-1:0] bin_new, bin_q, bin_d, delta_q, delta_d;
    logic [HW-1:0]    hd;
    logic             sv_q, sv_d, err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic logic [HW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [HW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) c = c + HW'(v[i]);
        return c;
    endfunction

    assign g_sync  = sync_q[SYNC_STAGES-1];
    assign bin_new = gray2bin(g_sync);
    assign hd      = popcount(g_sync ^ g_prev_q);

    // synchroniser shift: runs every edge regardless of en
    always_comb begin
        sync_d[0] = gray_in;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    // next state: resync beats en; a violation beats a simultaneous clr_err
    always_comb begin
        state_d  = state_q;
        g_prev_d = g_prev_q;
        bin_d    = bin_q;
        delta_d  = delta_q;
        sv_d     = 1'b0;
        err_d    = clr_err ? 1'b0 : err_q;
        cnt_d    = clr_err ? 8'd0 : cnt_q;
        if (resync) begin
            state_d = INIT;
        end else if (en) begin
            if (state_q == INIT) begin
                bin_d    = bin_new;
                g_prev_d = g_sync;
                delta_d  = '0;
                state_d  = TRACK;
            end else if (hd != '0) begin
                bin_d    = bin_new;
                delta_d  = bin_new - bin_q;
                g_prev_d = g_sync;
                sv_d     = 1'b1;
                if (hd >= HW'(2)) begin
                    err_d = 1'b1;
                    cnt_d = clr_err ? 8'd1 : (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
                end
            end
        end
    end

    // state and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            state_q  <= INIT;
            g_prev_q <= '0;
            bin_q    <= '0;
            delta_q  <= '0;
            sv_q     <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
            state_q  <= state_d;
            g_prev_q <= g_prev_d;
            bin_q    <= bin_d;
            delta_q  <= delta_d;
            sv_q     <= sv_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign binary_out = bin_q;
    assign delta      = delta_q;
    assign step_valid = sv_q;
    assign err        = err_q;
    assign err_cnt    = cnt_q;
    assign locked     = (state_q == TRACK);

endmodule

// File: tb/tb_gray_rx_decoder.sv
// tb_gray_rx_decoder: directed checks of sync latency, decode, wrap, violations, clr_err, en and resync
module tb_gray_rx_decoder;

    logic       clk = 1'b0;
    logic       rst_n, en, resync, clr_err;
    logic [3:0] gray_in, binary_out, delta;
    logic       step_valid, err, locked;
    logic [7:0] err_cnt;
    int         checks = 0, failures = 0;
    int         pulses;

    logic [3:0] wrap_g [11] = '{4'b0111, 4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111,
                                4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    gray_rx_decoder #(.WIDTH(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .en(en), .resync(resync),
        .clr_err(clr_err), .binary_out(binary_out), .delta(delta),
        .step_valid(step_valid), .err(err), .err_cnt(err_cnt), .locked(locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // apply one Gray value, run 4 edges with en=1, expect exactly one step pulse
    task automatic do_step(input string tag, input logic [3:0] g, input logic [3:0] eb,
                           input logic [3:0] ed, input logic ee, input logic [7:0] ec);
        gray_in = g;
        pulses = 0;
        repeat (4) begin
            tick();
            pulses += int'(step_valid);
        end
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_bin"}, binary_out, eb);
        check({tag, "_delta"}, delta, ed);
        check({tag, "_err"}, err, ee);
        check({tag, "_cnt"}, err_cnt, ec);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; resync = 1'b0; clr_err = 1'b0; gray_in = 4'b0110;
        #3;
        check("rst_bin", binary_out, 0);
        check("rst_delta", delta, 0);
        check("rst_sv", step_valid, 0);
        check("rst_err", err, 0);
        check("rst_cnt", err_cnt, 0);
        check("rst_locked", locked, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("fill_locked", locked, 0);
        en = 1'b1;
        tick();
        check("init_bin", binary_out, 4);
        check("init_locked", locked, 1);
        check("init_sv", step_valid, 0);
        check("init_delta", delta, 0);
        check("init_err", err, 0);

        gray_in = 4'b0000; en = 1'b0; resync = 1'b1;
        tick();
        resync = 1'b0;
        check("rs0_locked", locked, 0);
        check("rs0_bin_hold", binary_out, 4);
        tick();
        en = 1'b1;
        tick();
        check("rs0_bin", binary_out, 0);
        check("rs0_locked2", locked, 1);

        do_step("cnt1", 4'b0001, 4'd1, 4'd1, 1'b0, 8'd0);
        do_step("cnt2", 4'b0011, 4'd2, 4'd1, 1'b0, 8'd0);
        do_step("cnt3", 4'b0010, 4'd3, 4'd1, 1'b0, 8'd0);
        do_step("cnt4", 4'b0110, 4'd4, 4'd1, 1'b0, 8'd0);
        for (int i = 0; i < 11; i++) do_step("up", wrap_g[i], 4'(i + 5), 4'd1, 1'b0, 8'd0);
        do_step("wrap", 4'b0000, 4'd0, 4'd1, 1'b0, 8'd0);

        do_step("jmp1", 4'b0011, 4'd2, 4'd2, 1'b1, 8'd1);
        do_step("jmp2", 4'b0100, 4'd7, 4'd5, 1'b1, 8'd2);
        do_step("jmp3", 4'b0001, 4'd1, 4'd10, 1'b1, 8'd3);
        do_step("jmp4", 4'b0110, 4'd4, 4'd3, 1'b1, 8'd4);
        do_step("jmp5", 4'b0000, 4'd0, 4'd12, 1'b1, 8'd5);

        gray_in = 4'b0011;
        tick();
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clrjmp_sv", step_valid, 1);
        check("clrjmp_bin", binary_out, 2);
        check("clrjmp_err", err, 1);
        check("clrjmp_cnt", err_cnt, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err", err, 0);
        check("clr_cnt", err_cnt, 0);
        check("clr_sv", step_valid, 0);

        en = 1'b0;
        pulses = 0;
        gray_in = 4'b0010;
        repeat (3) begin tick(); pulses += int'(step_valid); end
        gray_in = 4'b0110;
        repeat (3) begin tick(); pulses += int'(step_valid); end
        gray_in = 4'b0111;
        repeat (4) begin tick(); pulses += int'(step_valid); end
        check("en0_pulses", pulses, 0);
        check("en0_bin", binary_out, 2);
        check("en0_delta", delta, 2);
        check("en0_locked", locked, 1);
        check("en0_err", err, 0);

        resync = 1'b1;
        tick();
        resync = 1'b0;
        check("rs_locked", locked, 0);
        check("rs_bin", binary_out, 2);
        check("rs_sv", step_valid, 0);
        gray_in = 4'b1100;
        tick();
        tick();
        en = 1'b1;
        tick();
        check("reacq_bin", binary_out, 8);
        check("reacq_delta", delta, 0);
        check("reacq_err", err, 0);
        check("reacq_cnt", err_cnt, 0);
        check("reacq_locked", locked, 1);
        check("reacq_sv", step_valid, 0);
        do_step("post", 4'b1101, 4'd9, 4'd1, 1'b0, 8'd0);

        #2 rst_n = 1'b0;
        #1;
        check("arst_bin", binary_out, 0);
        check("arst_delta", delta, 0);
        check("arst_locked", locked, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
